// File: rtl/cs_pkg.sv
// -----------------------------------------------------------------------------
// cs_pkg
// Shared definitions for the ADC configuration sequencer: the FSM state
// encoding, sequence sizing constants and the register-address helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } cs_state_t;

    localparam int         NUM_REGS   = 15;
    localparam logic [7:0] TMO_MAX    = 8'd255;
    localparam logic [1:0] MAX_RETRY  = 2'd3;
    localparam logic [7:0] REGAP_ADDR = 8'h0E;

    // The last entry of the sequence is the gap register, which has its own
    // fixed address; the others are written at their index.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        return (idx == 4'(NUM_REGS - 1)) ? REGAP_ADDR : {4'b0000, idx};
    endfunction

endpackage

// File: rtl/cs_tmo.sv
// -----------------------------------------------------------------------------
// cs_tmo
// Write-acknowledge timeout counter. Counts cycles while en is high and
// saturates at TMO_MAX; clr or rst return it to zero.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   clr     in   clear the count (held while not waiting for an ack)
//   en      in   count this cycle
//   expired out  this is the TMO_MAX-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module cs_tmo
    import cs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != TMO_MAX)) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of enabled cycles already completed, so the
    // current cycle is the TMO_MAX-th one when count reaches TMO_MAX-1.
    assign expired = en && (count == (TMO_MAX - 8'd1));

endmodule

// File: rtl/cs_adc_seq.sv
// -----------------------------------------------------------------------------
// cs_adc_seq
// Writes 15 configuration bytes (reg00..reg13 and regap) to the ADC register
// port, one request at a time, with NAK/timeout retries and fs/fd handshake
// with the command block.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   fs        in   start flag, held high until fd is seen
//   fd        out  done flag, held high until fs falls
//   cfg_regs  in   [119:0] reg00 in [7:0] .. reg13 in [111:104], regap [119:112]
//   hold      in   back-pressure, blocks issuing a new write
//   wr_req    out  register write request
//   wr_addr   out  [7:0] register address
//   wr_data   out  [7:0] register data
//   wr_ack    in   one-cycle write acknowledge
//   wr_nak    in   qualifies wr_ack as a failed write
//   busy      out  sequencer not idle
//   err       out  sequence failed, valid while fd is high
// -----------------------------------------------------------------------------
module cs_adc_seq
    import cs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         fs,
    output logic         fd,
    input  logic [119:0] cfg_regs,
    input  logic         hold,
    output logic         wr_req,
    output logic [7:0]   wr_addr,
    output logic [7:0]   wr_data,
    input  logic         wr_ack,
    input  logic         wr_nak,
    output logic         busy,
    output logic         err
);

    cs_state_t    state, state_next;
    logic [3:0]   idx, idx_next;
    logic [1:0]   retry, retry_next;
    logic [119:0] shadow, shadow_next;
    logic         tmo_clr, tmo_en, tmo_expired;

    cs_tmo u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State and sequence bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            retry  <= '0;
            shadow <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            retry  <= retry_next;
            shadow <= shadow_next;
        end
    end

    // Next-state and output decode. Outputs depend only on the current state
    // and registered index, so a reset or abort clears them one edge later.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        retry_next  = retry;
        shadow_next = shadow;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        fd          = 1'b0;
        err         = 1'b0;
        busy        = (state != ST_IDLE);
        tmo_clr     = 1'b1;
        tmo_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fs) state_next = ST_LOAD;
            end

            ST_LOAD: begin
                shadow_next = cfg_regs;
                idx_next    = '0;
                retry_next  = '0;
                state_next  = fs ? ST_WAIT : ST_IDLE;
            end

            ST_WAIT: begin
                if (!fs)        state_next = ST_IDLE;
                else if (!hold) state_next = ST_REQ;
            end

            ST_REQ: begin
                wr_req  = 1'b1;
                wr_addr = reg_addr(idx);
                wr_data = 8'(shadow >> {idx, 3'b000});
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                // An ack in the same cycle as the timeout still counts as
                // the write's answer.
                if (!fs) begin
                    state_next = ST_IDLE;
                end else if (wr_ack) begin
                    state_next = ST_GAP;
                    if (wr_nak) begin
                        retry_next = retry + 2'd1;
                    end else begin
                        idx_next   = idx + 4'd1;
                        retry_next = '0;
                    end
                end else if (tmo_expired) begin
                    state_next = ST_GAP;
                    retry_next = retry + 2'd1;
                end
            end

            ST_GAP: begin
                if (!fs)                          state_next = ST_IDLE;
                else if (retry == MAX_RETRY)      state_next = ST_ERR;
                else if (idx == 4'(NUM_REGS))     state_next = ST_DONE;
                else                              state_next = ST_WAIT;
            end

            ST_DONE: begin
                fd = 1'b1;
                if (!fs) state_next = ST_IDLE;
            end

            ST_ERR: begin
                fd  = 1'b1;
                err = 1'b1;
                if (!fs) state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cs_adc_seq.sv
// -----------------------------------------------------------------------------
// tb_cs_adc_seq
// Scoreboard bench for cs_adc_seq: a reference model turns a configuration
// and a per-write responder plan into the expected list of writes and the
// final outcome; a responder answers requests from the plan and a monitor
// compares every completed request and every fd assertion.
// -----------------------------------------------------------------------------
module tb_cs_adc_seq;

    logic         clk = 1'b0;
    logic         rst, fs, hold, wr_ack, wr_nak;
    logic [119:0] cfg_regs;
    logic         fd, wr_req, busy, err;
    logic [7:0]   wr_addr, wr_data;

    always #5 clk = ~clk;

    cs_adc_seq dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
        .fd       (fd),
        .cfg_regs (cfg_regs),
        .hold     (hold),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .wr_nak   (wr_nak),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        int delay;
        bit nak;
        bit noack;
    } rsp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         len;
    } exp_t;

    rsp_t plan_q[$];
    rsp_t rsp_q[$];
    exp_t exp_q[$];
    bit   done_q[$];

    int checks = 0;
    int errors = 0;
    int n_ok   = 0;
    bit resp_en   = 1'b1;
    bit mon_en    = 1'b1;
    bit hold_rand = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: walks the plan one write attempt at a time, applying
    // the retry/abandon rules, and records every request it expects to see.
    task automatic buildModel(input logic [119:0] cfg);
        int   idx, retry, k;
        rsp_t r;
        exp_t e;
        idx = 0; retry = 0; k = 0;
        while (1) begin
            if (k < plan_q.size()) r = plan_q[k];
            else                   r = '{2, 1'b0, 1'b0};
            k++;
            rsp_q.push_back(r);
            e.addr = (idx == 14) ? 8'h0E : 8'(idx);
            e.data = cfg[idx*8 +: 8];
            e.len  = r.noack ? 255 : r.delay;
            exp_q.push_back(e);
            if (r.noack || r.nak) begin
                retry++;
                if (retry == 3) begin done_q.push_back(1'b1); break; end
            end else begin
                idx++;
                retry = 0;
                if (idx == 15) begin done_q.push_back(1'b0); break; end
            end
        end
        plan_q.delete();
    endtask

    // Runs one complete sequence: start, wait for fd, keep fs high to see
    // that nothing restarts, then release fs.
    task automatic applyStimulus(input logic [119:0] cfg, input bit check_lat);
        int c;
        buildModel(cfg);
        cfg_regs = cfg;
        fs = 1'b1;
        @(negedge clk);
        if (check_lat) begin
            checkOutput("busy_after_start", busy, 1);
            checkOutput("lat_req_c1", wr_req, 0);
        end
        @(negedge clk);
        if (check_lat) checkOutput("lat_req_c2", wr_req, 0);
        @(negedge clk);
        if (check_lat) checkOutput("lat_req_c3", wr_req, 1);
        cfg_regs = ~cfg;
        c = 0;
        while (!fd && c < 20000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("fd_reached", fd, 1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("fd_held", fd, 1);
            checkOutput("no_restart", wr_req, 0);
        end
        fs = 1'b0;
        @(negedge clk);
        checkOutput("fd_fall", fd, 0);
        checkOutput("err_fall", err, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("writes_left", exp_q.size(), 0);
        checkOutput("outcomes_left", done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
        rsp_q.delete();
    endtask

    // Holds off the idx=7 write for 20 cycles of WAIT.
    task automatic holdTest();
        int c;
        c = 0;
        while (n_ok < 7 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        checkOutput("hold_reach", n_ok, 7);
        @(negedge clk);
        hold = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checkOutput("hold_req_low", wr_req, 0);
        end
        hold = 1'b0;
        @(negedge clk);
        checkOutput("hold_release_req", wr_req, 1);
        checkOutput("hold_release_addr", wr_addr, 7);
    endtask

    // Responder: answers each new request according to the next plan entry.
    initial begin : responder
        rsp_t r;
        int   cnt;
        bit   active;
        active = 1'b0;
        cnt    = 0;
        r      = '{1, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                active = 1'b0;
            end else begin
                wr_ack = 1'b0;
                wr_nak = 1'b0;
                if (!wr_req) begin
                    active = 1'b0;
                end else begin
                    if (!active) begin
                        active = 1'b1;
                        cnt    = 1;
                        if (rsp_q.size() > 0) r = rsp_q.pop_front();
                        else                  r = '{1, 1'b0, 1'b0};
                    end else begin
                        cnt++;
                    end
                    if (!r.noack && cnt == r.delay) begin
                        wr_ack = 1'b1;
                        wr_nak = r.nak;
                        active = 1'b0;
                        if (!r.nak) n_ok++;
                    end
                end
            end
        end
    end

    // Monitor: compares each finished request and each fd assertion against
    // the scoreboard queues.
    initial begin : monitor
        bit         prev_req, prev_fd, unstable;
        int         len;
        logic [7:0] a, d;
        exp_t       e;
        prev_req = 1'b0; prev_fd = 1'b0; unstable = 1'b0;
        len = 0; a = '0; d = '0;
        forever begin
            @(negedge clk);
            if (wr_req && !prev_req) begin
                len = 1; a = wr_addr; d = wr_data; unstable = 1'b0;
            end else if (wr_req) begin
                len++;
                if (wr_addr !== a || wr_data !== d) unstable = 1'b1;
            end else if (prev_req && mon_en) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", a, e.addr);
                    checkOutput("wr_data", d, e.data);
                    checkOutput("req_len", len, e.len);
                    checkOutput("req_stable", unstable, 0);
                end
            end
            if (fd && !prev_fd) begin
                if (done_q.size() == 0) checkOutput("unexpected_fd", done_q.size(), 1);
                else                    checkOutput("err_flag", err, done_q.pop_front());
            end
            prev_req = wr_req;
            prev_fd  = fd;
        end
    end

    initial begin : hold_gen
        forever begin
            @(negedge clk);
            if (hold_rand) hold = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [119:0] nom, rnd;
        logic [127:0] tmp;
        int           c;

        rst = 1'b1; fs = 1'b0; hold = 1'b0;
        wr_ack = 1'b0; wr_nak = 1'b0; cfg_regs = '0;
        for (int n = 0; n < 15; n++) nom[n*8 +: 8] = 8'(n + 16);

        repeat (2) @(negedge clk);
        checkOutput("rst_fd", fd, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_req", wr_req, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] nominal sequence");
        for (int i = 0; i < 15; i++) plan_q.push_back('{3, 1'b0, 1'b0});
        applyStimulus(nom, 1'b1);

        $display("[TB] nak on idx 5");
        for (int i = 0; i < 5; i++) plan_q.push_back('{3, 1'b0, 1'b0});
        plan_q.push_back('{3, 1'b1, 1'b0});
        applyStimulus(nom, 1'b1);

        $display("[TB] timeout on idx 2");
        plan_q.push_back('{3, 1'b0, 1'b0});
        plan_q.push_back('{3, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) plan_q.push_back('{0, 1'b0, 1'b1});
        applyStimulus(nom, 1'b1);

        $display("[TB] ack on the timeout cycle");
        plan_q.push_back('{255, 1'b0, 1'b0});
        applyStimulus(nom, 1'b1);

        $display("[TB] hold before idx 7");
        n_ok = 0;
        fork
            applyStimulus(nom, 1'b0);
            holdTest();
        join

        $display("[TB] abort during idx 9");
        mon_en = 1'b0;
        for (int i = 0; i < 9; i++) rsp_q.push_back('{2, 1'b0, 1'b0});
        rsp_q.push_back('{200, 1'b0, 1'b0});
        cfg_regs = nom;
        fs = 1'b1;
        c = 0;
        while (!(wr_req && wr_addr == 8'd9) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("abort_reach", wr_addr, 9);
        fs = 1'b0;
        @(negedge clk);
        checkOutput("abort_wr_req", wr_req, 0);
        checkOutput("abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("abort_no_fd", fd, 0);
        rsp_q.delete();
        mon_en = 1'b1;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        rnd = tmp[119:0];
        applyStimulus(rnd, 1'b1);

        $display("[TB] reset during request");
        mon_en = 1'b0;
        rsp_q.push_back('{100, 1'b0, 1'b0});
        fs = 1'b1;
        c = 0;
        while (!wr_req && c < 100) begin
            @(negedge clk);
            c++;
        end
        checkOutput("rst_req_reach", wr_req, 1);
        repeat (3) @(negedge clk);
        resp_en = 1'b0;
        rst = 1'b1;
        fs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_wr_req", wr_req, 0);
        checkOutput("midrst_wr_addr", wr_addr, 0);
        checkOutput("midrst_wr_data", wr_data, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_fd", fd, 0);
        checkOutput("midrst_err", err, 0);
        wr_ack = 1'b1;
        wr_nak = 1'b0;
        @(negedge clk);
        wr_ack = 1'b0;
        checkOutput("late_ack_busy", busy, 0);
        checkOutput("late_ack_wr_req", wr_req, 0);
        @(negedge clk);
        checkOutput("late_ack_fd", fd, 0);
        rsp_q.delete();
        resp_en = 1'b1;
        mon_en = 1'b1;

        $display("[TB] randomized sequences");
        hold_rand = 1'b1;
        repeat (6) begin
            for (int i = 0; i < 25; i++) begin
                plan_q.push_back('{delay: int'($urandom_range(1, 6)),
                                   nak:   ($urandom_range(0, 7) == 0),
                                   noack: ($urandom_range(0, 49) == 0)});
            end
            tmp = {$urandom, $urandom, $urandom, $urandom};
            rnd = tmp[119:0];
            applyStimulus(rnd, 1'b0);
        end
        hold_rand = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_adc_seq.md
CS_ADC_SEQ -- requirements
Module: cs_adc_seq

Interface
REQ-001 SHALL have a single clock domain, clock port clk; reset port rst is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: system clock (sys_clk domain).
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port fs, input, 1 bit: start flag from the command block, held high until fd is seen.
REQ-005 SHALL have port fd, output, 1 bit: done flag, held high until fs falls.
REQ-006 SHALL have port cfg_regs, input, 120 bits: reg00 in [7:0] through reg13 in [111:104], regap in [119:112].
REQ-007 SHALL have port hold, input, 1 bit: back-pressure (fifoa_full); no new write is issued while high.
REQ-008 SHALL have port wr_req, output, 1 bit: ADC register write request.
REQ-009 SHALL have port wr_addr, output, 8 bits: ADC register address.
REQ-010 SHALL have port wr_data, output, 8 bits: ADC register data.
REQ-011 SHALL have port wr_ack, input, 1 bit: one-cycle write acknowledge.
REQ-012 SHALL have port wr_nak, input, 1 bit: qualifies wr_ack as a failed write.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port err, output, 1 bit: sequence failed; valid while fd is high.

Function
REQ-015 SHALL implement states IDLE, LOAD, WAIT, REQ, GAP, DONE and ERR.
REQ-016 SHALL go IDLE->LOAD on fs=1 and, in LOAD, latch cfg_regs into a shadow register and clear idx, retry and timer.
REQ-017 SHALL go LOAD->WAIT, then WAIT->REQ on the first cycle with hold=0; wr_req first rises 2 cycles after fs is sampled high when hold=0.
REQ-018 SHALL, in REQ, drive wr_req=1, wr_data=shadow byte idx and wr_addr=idx for idx 0..13 or 8'h0E for idx 14 (regap), all stable until acknowledged.
REQ-019 SHALL treat wr_ack=1 with wr_nak=0 as success: wr_req drops next cycle, idx increments, retry clears, and the next state is GAP.
REQ-020 SHALL treat wr_ack=1 with wr_nak=1, or a timer reaching 255 cycles in REQ without ack, as a failure: retry increments, then GAP.
REQ-021 SHALL go GAP->ERR when retry=3, GAP->DONE when idx=15, and GAP->WAIT otherwise; GAP lasts exactly 1 cycle with wr_req=0.
REQ-022 SHALL ignore wr_ack outside REQ.
REQ-023 SHALL drive fd=1 in DONE with err=0, and fd=1 in ERR with err=1; both states return to IDLE on the cycle after fs=0, and fd, err fall together.
REQ-024 SHALL abort to IDLE if fs falls in LOAD, WAIT, REQ or GAP, driving wr_req=0 next cycle and never asserting fd.
REQ-025 SHALL give wr_ack priority over the timeout when both occur in the same cycle.
REQ-026 SHALL sample hold only in WAIT; hold rising during REQ does not withdraw the request.
REQ-027 SHALL, when fs stays high after DONE or ERR, not restart; a new run needs fs low for at least 1 cycle.
REQ-028 SHALL size idx at 4 bits with range 0..15, the timer at 8 bits saturating at 255 and cleared on entry to REQ, and retry at 2 bits.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, go to IDLE with fd=0, err=0, busy=0, wr_req=0, wr_addr=0, wr_data=0, idx=0, retry=0, timer=0 and the shadow register cleared.
REQ-030 SHALL, for rst asserted mid-transfer, drop wr_req on the next edge without waiting for wr_ack.

Structure
REQ-031 SHALL place the state encoding, NUM_REGS=15, TMO_MAX=255, MAX_RETRY=3 and REGAP_ADDR=8'h0E in a shared package cs_pkg.
REQ-032 SHALL implement the timeout counter as sub-module cs_tmo (inputs clk, rst, clr, en; output expired), instantiated once.

Verification
REQ-033 SHALL cover nominal operation: cfg_regs byte n = n+8'h10, ack 3 cycles after each req -> 15 writes with addr 0..13 then 0x0E and data 0x10..0x1E; fd=1 and err=0 after the last write.
REQ-034 SHALL cover a NAK: nak on the idx=5 write once -> the write repeats with addr 5 and the same data; the sequence completes with err=0.
REQ-035 SHALL cover timeout: no ack on idx=2 -> 3 requests, each lasting 255 cycles, with a 1-cycle gap; then fd=1 and err=1 with no idx=3 write issued.
REQ-036 SHALL cover hold: hold=1 for 20 cycles while in WAIT before idx=7 -> wr_req stays low for those 20 cycles and rises 1 cycle after hold falls.
REQ-037 SHALL cover abort: fs falls during idx=9 REQ -> wr_req=0 next cycle, busy=0, fd never rises; a new fs restarts at idx=0.
REQ-038 SHALL cover reset: rst pulsed for 1 cycle during REQ -> all outputs 0 next cycle; an ack arriving afterwards is ignored.
